// File: rtl/cnt_match_trigger_if.sv
// rtl/cnt_match_trigger_if.sv - Control/observation bundle for the counter match trigger
//
// Ports (master = driver of controls/observer of results, slave = trigger stage):
//   arm, disarm          single-cycle sequence start / abort requests
//   cnt_in[W]            counter slice under observation
//   match_val[W]         compare value
//   match_mask[W]        1 = bit participates in compare
//   match_cnt[8]         qualifying events required (0 behaves as 1)
//   holdoff[HW]          post-trigger dead cycles (0 = none)
//   trig_en              high while ARMED
//   trig_pulse           one-cycle trigger pulse
//   cap_val[W]           counter value of the completing event
//   event_cnt[8]         qualifying events seen in the current sequence
//   state[2]             0 IDLE, 1 ARMED, 2 TRIGGERED, 3 HOLDOFF
interface cnt_match_trigger_if #(
    parameter int W  = 6,
    parameter int HW = 16
);
    logic          arm;
    logic          disarm;
    logic [W-1:0]  cnt_in;
    logic [W-1:0]  match_val;
    logic [W-1:0]  match_mask;
    logic [7:0]    match_cnt;
    logic [HW-1:0] holdoff;
    logic          trig_en;
    logic          trig_pulse;
    logic [W-1:0]  cap_val;
    logic [7:0]    event_cnt;
    logic [1:0]    state;

    modport master (
        output arm, disarm, cnt_in, match_val, match_mask, match_cnt, holdoff,
        input  trig_en, trig_pulse, cap_val, event_cnt, state
    );

    modport slave (
        input  arm, disarm, cnt_in, match_val, match_mask, match_cnt, holdoff,
        output trig_en, trig_pulse, cap_val, event_cnt, state
    );
endinterface

// File: rtl/cnt_match_trigger.sv
// rtl/cnt_match_trigger.sv - Masked counter compare with event qualification, trigger pulse and holdoff
//
// Ports:
//   clk1   system clock
//   rstn   asynchronous active-low reset (released through a 2-flop synchronizer)
//   bus    cnt_match_trigger_if.slave: arm/disarm, cnt_in, match_val/mask,
//          match_cnt, holdoff in; trig_en, trig_pulse, cap_val, event_cnt, state out
//
// Build option: define CNT_MATCH_TRIG_EDGE_EN to count only rising edges of the
// compare result (a sustained match counts once); otherwise every matching
// ARMED cycle counts.
module cnt_match_trigger #(
    parameter int W  = 6,
    parameter int HW = 16
) (
    input  logic                clk1,
    input  logic                rstn,
    cnt_match_trigger_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_TRIG  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // Reset asserts asynchronously, releases on the clock.
    logic [1:0] rst_sync;
    logic       rst_n_i;

    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) rst_sync <= 2'b00;
        else       rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n_i = rst_sync[1];

    // Stage 1: compare result and sample registered every cycle.
    logic         hit;
    logic         match_q;
    logic [W-1:0] cnt_q;

    assign hit = ((bus.cnt_in ^ bus.match_val) & bus.match_mask) == '0;

    always_ff @(posedge clk1 or negedge rst_n_i) begin
        if (!rst_n_i) begin
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            match_q <= hit;
            cnt_q   <= bus.cnt_in;
        end
    end

    logic qual;

`ifdef CNT_MATCH_TRIG_EDGE_EN
    // Reset to 1 so a match already present when armed waits for a fresh edge.
    logic match_prev;

    always_ff @(posedge clk1 or negedge rst_n_i) begin
        if (!rst_n_i) match_prev <= 1'b1;
        else          match_prev <= match_q;
    end

    assign qual = match_q & ~match_prev;
`else
    assign qual = match_q;
`endif

    state_t        state_q, state_d;
    logic [7:0]    event_cnt_q, event_cnt_d;
    logic [W-1:0]  cap_q, cap_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          pulse_q, pulse_d;
    logic          trig_en_q, trig_en_d;

    logic [7:0] thr;
    logic [7:0] ev_inc;

    assign thr    = (bus.match_cnt == 8'd0) ? 8'd1 : bus.match_cnt;
    assign ev_inc = (event_cnt_q == 8'hFF) ? 8'hFF : event_cnt_q + 8'd1;

    always_ff @(posedge clk1 or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            event_cnt_q <= 8'd0;
            cap_q       <= '0;
            hold_q      <= '0;
            pulse_q     <= 1'b0;
            trig_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            event_cnt_q <= event_cnt_d;
            cap_q       <= cap_d;
            hold_q      <= hold_d;
            pulse_q     <= pulse_d;
            trig_en_q   <= trig_en_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        event_cnt_d = event_cnt_q;
        cap_d       = cap_q;
        hold_d      = hold_q;
        pulse_d     = 1'b0;

        if (bus.disarm) begin
            // Abort wins over arm and over a same-cycle qualifying event.
            state_d     = S_IDLE;
            event_cnt_d = 8'd0;
            hold_d      = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.arm) begin
                        state_d     = S_ARMED;
                        event_cnt_d = 8'd0;
                    end
                end
                S_ARMED: begin
                    if (qual) begin
                        event_cnt_d = ev_inc;
                        // >= so that lowering match_cnt below the running count
                        // fires on the next qualifying event.
                        if (ev_inc >= thr) begin
                            state_d = S_TRIG;
                            pulse_d = 1'b1;
                            cap_d   = cnt_q;
                        end
                    end
                end
                S_TRIG: begin
                    if (bus.holdoff != '0) begin
                        state_d = S_HOLD;
                        hold_d  = bus.holdoff;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_HOLD: begin
                    // Loaded with holdoff on entry, leave when it reads 1.
                    if (hold_q <= HW'(1)) begin
                        state_d = S_IDLE;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q - HW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        trig_en_d = (state_d == S_ARMED);
    end

    assign bus.trig_en    = trig_en_q;
    assign bus.trig_pulse = pulse_q;
    assign bus.cap_val    = cap_q;
    assign bus.event_cnt  = event_cnt_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_cnt_match_trigger.sv
// tb/tb_cnt_match_trigger.sv - Self-checking bench for cnt_match_trigger
module tb_cnt_match_trigger;

    logic clk1 = 1'b0;
    logic rstn = 1'b0;

    always #5 clk1 = ~clk1;

    cnt_match_trigger_if #(.W(6), .HW(16)) bus ();

    cnt_match_trigger #(.W(6), .HW(16)) dut (
        .clk1 (clk1),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " state"},      int'(bus.state), 0);
        chk({tag, " trig_en"},    int'(bus.trig_en), 0);
        chk({tag, " trig_pulse"}, int'(bus.trig_pulse), 0);
        chk({tag, " cap_val"},    int'(bus.cap_val), 0);
        chk({tag, " event_cnt"},  int'(bus.event_cnt), 0);
    endtask

    typedef struct packed {
        logic       arm;
        logic       disarm;
        logic [5:0] cnt;
        logic [7:0] mcnt;
        logic [15:0] hold;
        logic [1:0] st;
        logic       tp;
        logic       te;
        logic [7:0] ec;
        logic [5:0] cv;
    } vec_t;

    vec_t vecs [23];

    initial begin
        int npulse;
        int pk;
        int cvp;
        int ecp;
        int nhold;
        bit found;

        // arm dis cnt    mcnt   hold    | st   tp    te    ec     cv   (mask 0x03, val 0x01)
        vecs[0]  = '{1'b1, 1'b0, 6'h00, 8'd3, 16'd2, 2'd1, 1'b0, 1'b1, 8'd0, 6'h00};
        vecs[1]  = '{1'b0, 1'b0, 6'h05, 8'd3, 16'd2, 2'd1, 1'b0, 1'b1, 8'd0, 6'h00};
        vecs[2]  = '{1'b0, 1'b0, 6'h06, 8'd3, 16'd2, 2'd1, 1'b0, 1'b1, 8'd1, 6'h00};
        vecs[3]  = '{1'b0, 1'b0, 6'h09, 8'd3, 16'd2, 2'd1, 1'b0, 1'b1, 8'd1, 6'h00};
        vecs[4]  = '{1'b0, 1'b0, 6'h0D, 8'd3, 16'd2, 2'd1, 1'b0, 1'b1, 8'd2, 6'h00};
        vecs[5]  = '{1'b1, 1'b0, 6'h10, 8'd3, 16'd2, 2'd2, 1'b1, 1'b0, 8'd3, 6'h0D};
        vecs[6]  = '{1'b0, 1'b0, 6'h11, 8'd3, 16'd2, 2'd3, 1'b0, 1'b0, 8'd3, 6'h0D};
        vecs[7]  = '{1'b1, 1'b0, 6'h12, 8'd3, 16'd2, 2'd3, 1'b0, 1'b0, 8'd3, 6'h0D};
        vecs[8]  = '{1'b0, 1'b0, 6'h13, 8'd3, 16'd2, 2'd0, 1'b0, 1'b0, 8'd3, 6'h0D};
        vecs[9]  = '{1'b1, 1'b0, 6'h15, 8'd0, 16'd0, 2'd1, 1'b0, 1'b1, 8'd0, 6'h0D};
        vecs[10] = '{1'b0, 1'b0, 6'h16, 8'd0, 16'd0, 2'd2, 1'b1, 1'b0, 8'd1, 6'h15};
        vecs[11] = '{1'b0, 1'b0, 6'h17, 8'd0, 16'd0, 2'd0, 1'b0, 1'b0, 8'd1, 6'h15};
        vecs[12] = '{1'b1, 1'b1, 6'h01, 8'd5, 16'd0, 2'd0, 1'b0, 1'b0, 8'd0, 6'h15};
        vecs[13] = '{1'b1, 1'b0, 6'h01, 8'd5, 16'd0, 2'd1, 1'b0, 1'b1, 8'd0, 6'h15};
        vecs[14] = '{1'b0, 1'b0, 6'h01, 8'd5, 16'd0, 2'd1, 1'b0, 1'b1, 8'd1, 6'h15};
        vecs[15] = '{1'b0, 1'b0, 6'h01, 8'd5, 16'd0, 2'd1, 1'b0, 1'b1, 8'd2, 6'h15};
        vecs[16] = '{1'b0, 1'b1, 6'h01, 8'd5, 16'd0, 2'd0, 1'b0, 1'b0, 8'd0, 6'h15};
        vecs[17] = '{1'b0, 1'b0, 6'h01, 8'd5, 16'd0, 2'd0, 1'b0, 1'b0, 8'd0, 6'h15};
        vecs[18] = '{1'b1, 1'b0, 6'h01, 8'd5, 16'd0, 2'd1, 1'b0, 1'b1, 8'd0, 6'h15};
        vecs[19] = '{1'b0, 1'b0, 6'h01, 8'd5, 16'd0, 2'd1, 1'b0, 1'b1, 8'd1, 6'h15};
        vecs[20] = '{1'b0, 1'b0, 6'h25, 8'd5, 16'd0, 2'd1, 1'b0, 1'b1, 8'd2, 6'h15};
        vecs[21] = '{1'b0, 1'b0, 6'h21, 8'd2, 16'd0, 2'd2, 1'b1, 1'b0, 8'd3, 6'h25};
        vecs[22] = '{1'b0, 1'b0, 6'h00, 8'd2, 16'd0, 2'd0, 1'b0, 1'b0, 8'd3, 6'h25};

        bus.arm = 1'b0;
        bus.disarm = 1'b0;
        bus.cnt_in = 6'h00;
        bus.match_val = 6'h00;
        bus.match_mask = 6'h00;
        bus.match_cnt = 8'd1;
        bus.holdoff = 16'd0;

        tick();
        tick();
        chk_reset_vals("reset");
        rstn = 1'b1;
        tick();
        tick();
        tick();
        chk_reset_vals("post-release");

`ifndef CNT_MATCH_TRIG_EDGE_EN
        // Level-mode vector table: one record per clock.
        bus.match_mask = 6'h03;
        bus.match_val  = 6'h01;
        for (int i = 0; i < 23; i++) begin
            bus.arm       = vecs[i].arm;
            bus.disarm    = vecs[i].disarm;
            bus.cnt_in    = vecs[i].cnt;
            bus.match_cnt = vecs[i].mcnt;
            bus.holdoff   = vecs[i].hold;
            tick();
            chk($sformatf("vec%0d state", i),      int'(bus.state),      int'(vecs[i].st));
            chk($sformatf("vec%0d trig_pulse", i), int'(bus.trig_pulse), int'(vecs[i].tp));
            chk($sformatf("vec%0d trig_en", i),    int'(bus.trig_en),    int'(vecs[i].te));
            chk($sformatf("vec%0d event_cnt", i),  int'(bus.event_cnt),  int'(vecs[i].ec));
            chk($sformatf("vec%0d cap_val", i),    int'(bus.cap_val),    int'(vecs[i].cv));
        end
        bus.arm = 1'b0;
        bus.disarm = 1'b0;
`endif

        // Free-running counter, exact match on 0x2A, single event, no holdoff.
        bus.match_mask = 6'h3F;
        bus.match_val  = 6'h2A;
        bus.match_cnt  = 8'd1;
        bus.holdoff    = 16'd0;
        npulse = 0; pk = -1; cvp = -1; ecp = -1;
        for (int k = 0; k < 130; k++) begin
            bus.cnt_in = 6'(k);
            bus.arm    = (k == 0);
            tick();
            if (bus.trig_pulse) begin
                npulse++;
                pk  = k;
                cvp = int'(bus.cap_val);
                ecp = int'(bus.event_cnt);
                chk("single trig_en low with pulse", int'(bus.trig_en), 0);
            end
        end
        bus.arm = 1'b0;
        chk("single pulse count", npulse, 1);
        chk("single pulse latency step", pk, 43);
        chk("single cap_val", cvp, 'h2A);
        chk("single event_cnt", ecp, 1);
        chk("single end state", int'(bus.state), 0);

        // Holdoff of 5 with an ignored arm in the middle, then re-arm.
        bus.holdoff = 16'd5;
        nhold = 0;
        for (int k = 0; k < 71; k++) begin
            bus.cnt_in = 6'(k);
            bus.arm    = (k == 0) || (k == 46) || (k == 60);
            tick();
            if (bus.state == 2'd3) nhold++;
            if (k == 43) chk("hold trig state", int'(bus.state), 2);
            if (k == 44) chk("hold entry state", int'(bus.state), 3);
            if (k == 48) chk("hold last state", int'(bus.state), 3);
            if (k == 49) chk("hold exit idle", int'(bus.state), 0);
            if (k == 50) chk("hold arm ignored", int'(bus.state), 0);
            if (k == 60) chk("re-arm state", int'(bus.state), 1);
        end
        bus.arm = 1'b0;
        chk("hold cycle count", nhold, 5);

        // Reset asserted in the middle of HOLDOFF.
        found = 1'b0;
        for (int k = 71; k < 200 && !found; k++) begin
            bus.cnt_in = 6'(k);
            tick();
            if (bus.state == 2'd3) found = 1'b1;
        end
        chk("reach holdoff before reset", int'(found), 1);
        chk("cap before reset", int'(bus.cap_val), 'h2A);
        #2;
        rstn = 1'b0;
        #1;
        chk_reset_vals("async reset");
        tick();
        tick();
        rstn = 1'b1;
        npulse = 0;
        for (int k = 0; k < 12; k++) begin
            bus.cnt_in = 6'h11;
            tick();
            if (bus.trig_pulse) npulse++;
        end
        chk("no pulse after reset", npulse, 0);
        chk("idle after reset", int'(bus.state), 0);

`ifdef CNT_MATCH_TRIG_EDGE_EN
        // Edge mode: each 32-cycle run of bit5 set counts once.
        bus.match_mask = 6'h20;
        bus.match_val  = 6'h20;
        bus.match_cnt  = 8'd2;
        bus.holdoff    = 16'd0;
        npulse = 0; pk = -1; cvp = -1; ecp = -1;
        for (int k = 0; k < 140; k++) begin
            bus.cnt_in = 6'(k);
            bus.arm    = (k == 0);
            tick();
            if (k == 40) chk("edge first run count", int'(bus.event_cnt), 1);
            if (k == 63) chk("edge sustained once", int'(bus.event_cnt), 1);
            if (bus.trig_pulse) begin
                npulse++;
                pk  = k;
                cvp = int'(bus.cap_val);
                ecp = int'(bus.event_cnt);
            end
        end
        bus.arm = 1'b0;
        chk("edge pulse count", npulse, 1);
        chk("edge pulse step", pk, 97);
        chk("edge event_cnt", ecp, 2);
        chk("edge cap_val", cvp, 'h20);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cnt_match_trigger.md
# cnt_match_trigger

Programmable match-and-qualify trigger stage placed between the free-running counter and the on-chip debug core. It compares a masked slice of the counter against a match value, and counts qualifying events up to a programmable threshold. On reaching the threshold it emits a one-cycle trigger pulse, a captured counter snapshot, and a holdoff window. Its outputs drive the debug core's trigger-enable and trigger-data inputs.

## Interface
- W, 6, width of counter slice compared and captured
- HW, 16, width of holdoff counter

- clk1  in  1  system clock, from internal oscillator
- rstn  in  1  reset, asynchronous, active-low
- arm  in  1  single-cycle request to start a trigger sequence
- disarm  in  1  single-cycle request to abort and return to IDLE
- cnt_in  in  W  counter slice under observation
- match_val  in  W  compare value, quasi-static
- match_mask  in  W  1 = bit participates in compare; all-zero mask matches every cycle
- match_cnt  in  8  qualifying events required; 0 treated as 1
- holdoff  in  HW  post-trigger dead cycles; 0 means none
- trig_en  out  1  high while ARMED (gates debug-core trigger enable)
- trig_pulse  out  1  one-cycle pulse on trigger
- cap_val  out  W  cnt_in value of the event that completed the sequence
- event_cnt  out  8  qualifying events seen in the current sequence
- state  out  2  0 IDLE, 1 ARMED, 2 TRIGGERED, 3 HOLDOFF

## Operation
- Compare: hit = ((cnt_in ^ match_val) & match_mask) == 0.
- Stage 1 registers hit into match_q and cnt_in into cnt_q every cycle, in all states.
- Qualifying event: match_q while ARMED. In level mode every matching cycle counts. In edge mode see Configuration.
- IDLE: trig_en=0. arm -> ARMED, event_cnt cleared to 0.
- ARMED: trig_en=1. On a qualifying event, event_cnt increments.
  - If the incremented value is >= max(match_cnt,1): go to TRIGGERED, set trig_pulse, load cap_val <= cnt_q.
- TRIGGERED: lasts exactly one cycle. Then HOLDOFF if holdoff != 0, else IDLE.
- HOLDOFF: the down-counter is loaded with holdoff on entry and decrements each cycle. When it reaches 1, go to IDLE, so HOLDOFF lasts exactly holdoff cycles.
- event_cnt saturates at 255 and holds its value through TRIGGERED, HOLDOFF and IDLE until the next arm.
- cap_val holds until the next trigger.
- arm is ignored outside IDLE.
- disarm in any state: IDLE next cycle, event_cnt cleared, holdoff counter cleared, no trig_pulse. cap_val is kept.
- arm and disarm in the same cycle: disarm wins.
- match_cnt changed while ARMED: the new value applies from the next comparison. If event_cnt already >= the new value, the next qualifying event triggers.

## Timing
- Reset values: state=IDLE, trig_en=0, trig_pulse=0, cap_val=0, event_cnt=0, match_q=0, cnt_q=0, holdoff counter=0.
- Reset is asynchronous assert and synchronous release, with a 2-flop synchronizer on rstn.
- Latency: a cnt_in sample in cycle N that completes the sequence gives state=TRIGGERED and trig_pulse=1 in cycle N+2. cap_val is valid from cycle N+2.
- arm seen at the edge closing cycle N gives trig_en=1 in cycle N+1. The first comparable sample is cnt_in of cycle N, via match_q.
- trig_en drops in the same cycle trig_pulse rises.
- All outputs are registered; none is combinational from inputs.
- Reset mid-operation aborts immediately; no pulse is generated.

## Configuration
- Macro CNT_MATCH_TRIG_EDGE_EN.
- Defined: a qualifying event requires a rising edge of the compare result, i.e. match_q=1 and the previous match_q=0. A sustained match counts once.
  - The previous match_q register is reset to 1, so a match already present at arm does not count until it drops and reasserts.
- Undefined: level mode. Every ARMED cycle with match_q=1 counts. The extra register is not instantiated.

## Test plan
- Free-running 6-bit counter; mask=0x3F, val=0x2A, match_cnt=1, holdoff=0; arm. Required: trig_pulse exactly once, two cycles after cnt_in=0x2A; cap_val=0x2A; then state IDLE.
- Mask=0x03, val=0x01, match_cnt=3, level mode. Required: trigger on the third cnt_in with low bits 01 after arm; event_cnt=3; cap_val low bits=01.
- Edge mode, mask=0x20, val=0x20, match_cnt=2. Required: each run of 32 matching cycles counts once; trigger on the second run; event_cnt=2.
- holdoff=5 after a trigger. Required: HOLDOFF for exactly 5 cycles; arm pulsed during HOLDOFF is ignored; arm after IDLE re-arms.
- arm and disarm in the same cycle from IDLE stays IDLE. disarm while ARMED with event_cnt=2 gives IDLE next cycle and event_cnt=0, with no pulse.
- rstn low mid-HOLDOFF. Required: all outputs at reset values asynchronously, and no trig_pulse after release.
